// File: rtl/move_pulse_gen_pkg.sv
// Shared definitions for the move-pulse producer: move bus bit map, screen bounds,
// per-key FSM state encoding and the opposite-direction masking helper.
package move_pulse_gen_pkg;

  localparam int MAX_X = 639;
  localparam int MAX_Y = 479;

  localparam int MV_LEFT  = 0;
  localparam int MV_YINC  = 1;
  localparam int MV_YDEC  = 2;
  localparam int MV_RIGHT = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HOLD     = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_RELEASE  = 3'd4
  } key_state_e;

  // Opposite directions fired together cancel each other; other combinations pass.
  function automatic logic [3:0] mask_opposite(input logic [3:0] fire);
    logic [3:0] res;
    res = fire;
    if (fire[MV_LEFT] && fire[MV_RIGHT]) begin
      res[MV_LEFT]  = 1'b0;
      res[MV_RIGHT] = 1'b0;
    end else begin
      res[MV_LEFT]  = fire[MV_LEFT];
      res[MV_RIGHT] = fire[MV_RIGHT];
    end
    if (fire[MV_YINC] && fire[MV_YDEC]) begin
      res[MV_YINC] = 1'b0;
      res[MV_YDEC] = 1'b0;
    end else begin
      res[MV_YINC] = fire[MV_YINC];
      res[MV_YDEC] = fire[MV_YDEC];
    end
    return res;
  endfunction

endpackage

// File: rtl/move_pulse_gen_key_repeat.sv
// One button channel: 2-flop synchronizer, debounce / hold / auto-repeat FSM and its
// shared counter. fire is combinational and high on the edge a pulse is due.
module key_repeat #(
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int CNT_W        = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic fire
);
  import move_pulse_gen_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [1:0]       sync_r;
  logic             s_s;
  key_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             fire_s;

  assign s_s  = sync_r[1];
  assign fire = fire_s;

  // Bring the asynchronous button level into the clk domain; released after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], btn_n};
    end
  end

  // A release seen on the firing edge wins, so every fire term requires s low.
  always_comb begin
    fire_s = 1'b0;
    case (state_r)
      ST_DEBOUNCE: fire_s = (!s_s) && (cnt_r == DEB_LAST);
      ST_HOLD:     fire_s = (!s_s) && (cnt_r == DLY_LAST);
      ST_REPEAT:   fire_s = (!s_s) && (cnt_r == RPT_LAST);
      default:     fire_s = 1'b0;
    endcase
  end

  // Channel FSM; the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!s_s) begin
            state_r <= ST_DEBOUNCE;
            cnt_r   <= CNT_ZERO;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end
        end
        ST_DEBOUNCE: begin
          if (s_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == DEB_LAST) begin
            state_r <= ST_HOLD;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (s_s) begin
            state_r <= ST_RELEASE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == DLY_LAST) begin
            state_r <= ST_REPEAT;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (s_s) begin
            state_r <= ST_RELEASE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == RPT_LAST) begin
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          // Any bounce back to low restarts the release debounce window.
          if (!s_s) begin
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == DEB_LAST) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: rtl/move_pulse_gen.sv
// Four debounced, auto-repeating push-button channels driving the registered
// active-low move bus; simultaneous opposite directions are cancelled.
module move_pulse_gen #(
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int CNT_W        = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic [3:0] move
);
  import move_pulse_gen_pkg::*;

  logic [3:0] fire_s;
  logic [3:0] fire_q_s;
  logic [3:0] move_r;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_repeat #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .CNT_W        (CNT_W)
    ) u_key (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_n[i]),
      .fire  (fire_s[i])
    );
  end

  assign fire_q_s = mask_opposite(fire_s);
  assign move     = move_r;

  // Output register: move is low only for the cycle after a firing edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      move_r <= 4'b1111;
    end else begin
      move_r <= ~fire_q_s;
    end
  end

endmodule

// File: tb/tb_move_pulse_gen.sv
// Self-checking bench for move_pulse_gen: directed vector table, hand-timed corner
// sequences and randomized button activity against a timestamp-based reference model.
module tb_move_pulse_gen;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int CW  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_n = 4'b1111;
  logic [3:0] move;

  move_pulse_gen #(
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .CNT_W        (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .move  (move)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: 0 = up, 1 = pressed (since t0), 2 = releasing (since t0)
  int         tnow = 0;
  int         mode [4];
  int         t0 [4];
  bit         fired [4];
  logic [3:0] b1 = 4'b1111;
  logic [3:0] b2 = 4'b1111;
  logic [3:0] exp_move = 4'b1111;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] exp;
  } vec_t;
  vec_t vec [22];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at edge %0d: move=%b expected %b", name, tnow, act, exp);
  endtask

  task automatic model_edge(input logic r, input logic [3:0] btn);
    logic [3:0] s;
    logic [3:0] f;
    int e;
    tnow++;
    if (!r) begin
      b1 = 4'b1111;
      b2 = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        mode[i]  = 0;
        fired[i] = 1'b0;
      end
      exp_move = 4'b1111;
    end else begin
      s  = b2;
      b2 = b1;
      b1 = btn;
      f  = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        case (mode[i])
          0: if (!s[i]) begin mode[i] = 1; t0[i] = tnow; fired[i] = 1'b0; end
          1: begin
            if (s[i]) begin
              if (fired[i]) begin mode[i] = 2; t0[i] = tnow; end
              else mode[i] = 0;
            end else begin
              e = tnow - t0[i];
              if (e == DEB || (e >= DEB + RD && (e - DEB - RD) % RR == 0)) begin
                f[i] = 1'b1;
                fired[i] = 1'b1;
              end
            end
          end
          default: begin
            if (!s[i]) t0[i] = tnow;
            else if (tnow - t0[i] == DEB) mode[i] = 0;
          end
        endcase
      end
      if (f[0] && f[3]) begin f[0] = 1'b0; f[3] = 1'b0; end
      if (f[1] && f[2]) begin f[1] = 1'b0; f[2] = 1'b0; end
      exp_move = ~f;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(rst, btn_n);
    #1;
    check("model", move, exp_move);
  endtask

  initial begin
    int hold [4];
    logic [3:0] rb;
    logic [3:0] e;

    // Vectors: reset with btn[0] held, one press through HOLD, release before repeat
    vec[0] = '{1'b0, 4'b1110, 4'b1111};
    vec[1] = '{1'b0, 4'b1110, 4'b1111};
    for (int j = 0; j < 20; j++) begin
      vec[j+2].rst = 1'b1;
      vec[j+2].btn = (j < 12) ? 4'b1110 : 4'b1111;
      vec[j+2].exp = (j == 6) ? 4'b1110 : 4'b1111;
    end
    for (int i = 0; i < 22; i++) begin
      rst   = vec[i].rst;
      btn_n = vec[i].btn;
      tick();
      check("vec_table", move, vec[i].exp);
    end

    // Bouncing button never survives debounce
    for (int j = 0; j < 24; j++) begin
      btn_n = (j < 16 && ((j / 2) % 2 == 0)) ? 4'b1101 : 4'b1111;
      tick();
      check("bounce", move, 4'b1111);
    end

    // Hold right: first pulse, delay, then repeat every RR until release reaches s
    for (int j = 0; j < 52; j++) begin
      btn_n = (j < 40) ? 4'b0111 : 4'b1111;
      tick();
      e = (j == 6 || (j >= 16 && j <= 40 && (j - 16) % 3 == 0)) ? 4'b0111 : 4'b1111;
      check("hold_repeat", move, e);
    end

    // Opposite pair cancels, including its repeat pulses
    for (int j = 0; j < 32; j++) begin
      btn_n = (j < 20) ? 4'b0110 : 4'b1111;
      tick();
      check("opposite_pair", move, 4'b1111);
    end

    // Non-opposite pair pulses together
    for (int j = 0; j < 20; j++) begin
      btn_n = (j < 8) ? 4'b1100 : 4'b1111;
      tick();
      check("adjacent_pair", move, (j == 6) ? 4'b1100 : 4'b1111);
    end

    // Release glitch during REPEAT, re-press after release debounce, reset mid-REPEAT
    for (int j = 0; j < 64; j++) begin
      rst = (j == 58 || j == 59) ? 1'b0 : 1'b1;
      btn_n = (j < 18 || (j >= 20 && j < 30) || (j >= 36 && j < 58)) ? 4'b1011 : 4'b1111;
      tick();
      e = (j == 6 || j == 16 || j == 19 || j == 42 || j == 52 || j == 55) ? 4'b1011 : 4'b1111;
      check("release_reset", move, e);
    end

    // Randomized button holds with occasional reset, checked by the model
    rst   = 1'b1;
    btn_n = 4'b1111;
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(0, 8);
    for (int c = 0; c < 1500; c++) begin
      rb = btn_n;
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          rb[i]   = ~rb[i];
          hold[i] = rb[i] ? $urandom_range(1, 12) : $urandom_range(1, 30);
        end else begin
          hold[i]--;
        end
      end
      btn_n = rb;
      rst   = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
